// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl: ALU selector decode plus an iterative unsigned mul/div/rem
// unit. The unit takes WIDTH iterations and stalls the pipeline while it runs.
module alu_mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [3:0]       aluop,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       ops,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_REM} mop_t;

  state_t           state, state_nx;
  mop_t             mop, mop_in;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, opb;       // acc/remainder, multiplier/quotient, multiplicand/divisor
  logic [WIDTH-1:0] hi_nx, lo_nx, opb_nx, fin;
  logic [WIDTH:0]   trial;
  logic             dz, dz_in, mc, accept;

  // Combinational ALU selector decode, active regardless of state
  always_comb begin
    ops = 4'b1111;
    case (aluop)
      4'b0000: ops = 4'b0010;
      4'b0001: ops = 4'b0110;
      4'b0011: ops = 4'b1011;
      4'b0100: ops = 4'b0000;
      4'b0101: ops = 4'b0001;
      4'b0110: ops = 4'b1001;
      4'b0111: ops = 4'b0111;
      4'b1000: ops = 4'b1111;
      4'b1111: ops = 4'b1100;
      4'b0010: begin
        case (func)
          6'b000000: ops = 4'b1101;
          6'b100100: ops = 4'b0000;
          6'b100101: ops = 4'b0001;
          6'b100000: ops = 4'b0010;
          6'b011011: ops = 4'b0011;
          6'b100111: ops = 4'b0100;
          6'b000010: ops = 4'b0101;
          6'b100010: ops = 4'b0110;
          6'b011010: ops = 4'b1000;
          6'b101010: ops = 4'b1001;
          default:   ops = 4'b1111;
        endcase
      end
      default: ops = 4'b1111;
    endcase
  end

  // Multi-cycle classification, accept and stall generation
  always_comb begin
    mc     = (aluop == 4'b0010) && (ops == 4'b0101 || ops == 4'b1000 || ops == 4'b0011);
    mop_in = (ops == 4'b0101) ? OP_MUL : (ops == 4'b1000) ? OP_DIV : OP_REM;
    dz_in  = (mop_in != OP_MUL) && (b == '0);
    accept = (state != RUN) && valid_in && mc;
    stall  = (state == RUN) || accept;
    result_valid = (state == DONE);
    div_by_zero  = (state == DONE) && dz;
  end

  // Next-state logic; DONE accepts like IDLE so ops can run back to back
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nx = dz_in ? DONE : RUN;
        else        state_nx = IDLE;
      end
      RUN:     if (cnt == '0) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // One shift-add or restoring-divide step
  always_comb begin
    trial  = {hi, lo[WIDTH-1]} - {1'b0, opb};
    hi_nx  = hi;
    lo_nx  = lo;
    opb_nx = opb;
    if (mop == OP_MUL) begin
      hi_nx  = lo[0] ? hi + opb : hi;
      lo_nx  = lo >> 1;
      opb_nx = opb << 1;
    end else if (!trial[WIDTH]) begin
      hi_nx = trial[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nx = {hi[WIDTH-2:0], lo[WIDTH-1]};
      lo_nx = {lo[WIDTH-2:0], 1'b0};
    end
    fin = (mop == OP_DIV) ? lo_nx : hi_nx;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Operand capture, iteration registers and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      opb    <= '0;
      cnt    <= '0;
      mop    <= OP_MUL;
      dz     <= 1'b0;
      result <= '0;
    end else if (accept) begin
      hi  <= '0;
      lo  <= (mop_in == OP_MUL) ? b : a;
      opb <= (mop_in == OP_MUL) ? a : b;
      cnt <= CW'(WIDTH - 1);
      mop <= mop_in;
      dz  <= dz_in;
      if (dz_in) result <= (mop_in == OP_DIV) ? '1 : a;
    end else if (state == RUN) begin
      hi  <= hi_nx;
      lo  <= lo_nx;
      opb <= opb_nx;
      cnt <= cnt - 1'b1;
      if (cnt == '0) result <= fin;
    end
  end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Directed bench for alu_mdu_ctrl at WIDTH=8 with hand-computed expectations.
module tb_alu_mdu_ctrl;
  localparam int W = 8;
  localparam logic [5:0] F_MUL = 6'h02, F_DIV = 6'h1A, F_REM = 6'h1B;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic [3:0]   aluop = 4'h0;
  logic [5:0]   func = 6'h0;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0]   ops;
  logic         stall, result_valid, div_by_zero;
  logic [W-1:0] result;
  int total = 0, bad = 0;

  alu_mdu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .aluop(aluop), .func(func),
    .a(a), .b(b), .ops(ops), .stall(stall), .result(result),
    .result_valid(result_valid), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected selector, written from the decode table
  function automatic logic [3:0] exp_ops(input logic [3:0] op, input logic [5:0] f);
    case (op)
      4'h0: return 4'h2;  4'h1: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h0;  4'h5: return 4'h1;  4'h6: return 4'h9;
      4'h7: return 4'h7;  4'h8: return 4'hF;  4'hF: return 4'hC;
      4'h2: case (f)
        6'h00: return 4'hD;  6'h24: return 4'h0;  6'h25: return 4'h1;
        6'h20: return 4'h2;  6'h1B: return 4'h3;  6'h27: return 4'h4;
        6'h02: return 4'h5;  6'h22: return 4'h6;  6'h1A: return 4'h8;
        6'h2A: return 4'h9;  default: return 4'hF;
      endcase
      default: return 4'hF;
    endcase
  endfunction

  // Present a multi-cycle op in the current cycle (cycle 0)
  task automatic start(input logic [5:0] f, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input string tag);
    valid_in = 1'b1; aluop = 4'b0010; func = f; a = aa; b = bb;
    #1;
    chk({tag, " stall c0"}, 32'(stall), 32'd1);
  endtask

  // Step through cycles 1..lat; DONE expected in cycle lat
  task automatic finish(input logic [W-1:0] er, input logic edz, input int lat, input string tag);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      #1;
      if (c < lat) begin
        chk($sformatf("%s stall c%0d", tag, c), 32'(stall), 32'd1);
        chk($sformatf("%s rv c%0d", tag, c), 32'(result_valid), 32'd0);
      end else begin
        chk({tag, " rv"}, 32'(result_valid), 32'd1);
        chk({tag, " result"}, 32'(result), 32'(er));
        chk({tag, " dz"}, 32'(div_by_zero), 32'(edz));
        chk({tag, " stall done"}, 32'(stall), 32'd0);
      end
    end
  endtask

  task automatic run_op(input logic [5:0] f, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] er, input logic edz, input int lat, input string tag);
    @(posedge clk); #1;
    start(f, aa, bb, tag);
    finish(er, edz, lat, tag);
  endtask

  initial begin
    int seen;
    // Reset state
    #3;
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst rv", 32'(result_valid), 32'd0);
    chk("rst dz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Decode sweep: every aluop, then every func under R-type
    for (int i = 0; i < 16; i++) begin
      aluop = 4'(i); func = 6'h3F; valid_in = 1'b1;
      #1;
      chk($sformatf("ops aluop=%0h", i), 32'(ops), 32'(exp_ops(4'(i), 6'h3F)));
      chk($sformatf("stall aluop=%0h", i), 32'(stall), 32'd0);
    end
    aluop = 4'b0010;
    for (int f = 0; f < 64; f++) begin
      func = 6'(f);
      valid_in = !(func == F_MUL || func == F_DIV || func == F_REM);
      #1;
      chk($sformatf("ops func=%0h", f), 32'(ops), 32'(exp_ops(4'b0010, 6'(f))));
      chk($sformatf("stall func=%0h", f), 32'(stall), 32'd0);
    end
    valid_in = 1'b0;

    // Multiply, divide, modulo
    run_op(F_MUL, 8'd13, 8'd11, 8'h8F, 1'b0, 9, "mul13x11");
    @(posedge clk); #2;
    chk("hold result", 32'(result), 32'h8F);
    chk("hold rv", 32'(result_valid), 32'd0);
    run_op(F_MUL, 8'd200, 8'd3, 8'h58, 1'b0, 9, "mul200x3");
    run_op(F_DIV, 8'd200, 8'd7, 8'd28, 1'b0, 9, "div200/7");
    run_op(F_REM, 8'd200, 8'd7, 8'd4, 1'b0, 9, "rem200%7");

    // Divide by zero
    run_op(F_DIV, 8'h5A, 8'h00, 8'hFF, 1'b1, 1, "div0");
    run_op(F_REM, 8'h5A, 8'h00, 8'h5A, 1'b1, 1, "rem0");

    // Back-to-back: new multiply presented during DONE of a divide
    run_op(F_DIV, 8'd200, 8'd7, 8'd28, 1'b0, 9, "b2b div");
    start(F_MUL, 8'd5, 8'd6, "b2b mul");
    chk("b2b rv in done", 32'(result_valid), 32'd1);
    chk("b2b result in done", 32'(result), 32'd28);
    finish(8'd30, 1'b0, 9, "b2b mul");

    // Reset in the middle of a multiply
    @(posedge clk); #1;
    start(F_MUL, 8'd13, 8'd11, "rstmid");
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1 valid_in = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid stall", 32'(stall), 32'd0);
    chk("rstmid result", 32'(result), 32'd0);
    chk("rstmid rv", 32'(result_valid), 32'd0);
    chk("rstmid dz", 32'(div_by_zero), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #2;
      if (result_valid || stall) seen++;
    end
    chk("rstmid no rv after release", 32'(seen), 32'd0);
    run_op(F_MUL, 8'd13, 8'd11, 8'h8F, 1'b0, 9, "post-rst mul");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_mdu_ctrl.md
# alu_mdu_ctrl

Parametrised successor to the datapath's ALU control decoder. It still turns `aluop`/`func` into the 4-bit ALU selector for single-cycle operations. It additionally owns an iterative unsigned multiply/divide unit that executes `*`, `/` and `%` over WIDTH+1 cycles, with a stall/result handshake toward the pipeline. It sits between the main control, the register-file read ports and the writeback mux.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  instruction present on `aluop`/`func`/`a`/`b` this cycle.
- `aluop`  in  4  ALU operation class from main control.
- `func`  in  6  R-type function field.
- `a`  in  WIDTH  operand A (dividend / multiplicand).
- `b`  in  WIDTH  operand B (divisor / multiplier).
- `ops`  out  4  combinational ALU selector.
- `stall`  out  1  freezes upstream pipeline stages.
- `result`  out  WIDTH  multi-cycle result; valid only while `result_valid` is high.
- `result_valid`  out  1  one-cycle pulse; `result` must be written back this cycle.
- `div_by_zero`  out  1  pulses with `result_valid` when a `/` or `%` had `b == 0`.

## Operation
- Decode is combinational and always active, independent of state:
  - `aluop` 0000 → 0010; 0001 → 0110; 0011 → 1011; 0100 → 0000; 0101 → 0001; 0110 → 1001; 0111 → 0111; 1000 → 1111; 1111 → 1100.
  - `aluop` 0010 (R-type), selected by `func`: 000000 → 1101; 100100 → 0000; 100101 → 0001; 100000 → 0010; 011011 → 0011 (`%`); 100111 → 0100; 000010 → 0101 (`*`); 100010 → 0110; 011010 → 1000 (`/`); 101010 → 1001; any other `func` → 1111.
  - Any other `aluop` → 1111.
- Multi-cycle op (`mc`): `aluop` == 0010 and `ops` ∈ {0101, 1000, 0011}. All other ops are single-cycle: no stall, no `result_valid`.
- FSM states IDLE, RUN, DONE.
  - Accept condition: state ∈ {IDLE, DONE} and `valid_in` and `mc`. On accept, capture `a`, `b` and the op; load counter = WIDTH−1.
  - IDLE: on accept, go to RUN, except `/` or `%` with `b == 0`, which goes directly to DONE with the div-by-zero flag set. Otherwise stay in IDLE.
  - RUN: each cycle performs one iteration and decrements the counter. When the iteration runs with counter == 0, go to DONE.
  - DONE: `result_valid` = 1. Behaves exactly as IDLE for acceptance (back-to-back ops allowed); otherwise go to IDLE.
  - `valid_in` in RUN is ignored; the pipeline is stalled, so inputs are held.
- Multiply: unsigned shift-add. Result is the low WIDTH bits of `a*b`; overflow is discarded.
- Divide / modulo: unsigned restoring division, one quotient bit per cycle. `/` returns the quotient, `%` the remainder.
- Divide by zero: `/` returns all-ones, `%` returns `a`, and `div_by_zero` = 1.
- Reset, including mid-operation: state IDLE; `result`, counter, captured operands and flag all 0; any in-flight op is discarded with no `result_valid`.

## Timing
- Reset values: `stall` 0, `result` 0, `result_valid` 0, `div_by_zero` 0. `ops` follows its inputs combinationally.
- `stall` = (state == RUN) | (accept condition true). It is therefore high combinationally in the accept cycle.
- Normal op accepted in cycle 0:
  - RUN occupies cycles 1..WIDTH.
  - DONE is cycle WIDTH+1, with `result_valid` = 1 and `stall` = 0 (unless a new `mc` is accepted that cycle).
  - `stall` is high in cycles 0..WIDTH.
- Divide by zero accepted in cycle 0: DONE in cycle 1; `stall` is high only in cycle 0.
- `result` is registered and holds its last value after DONE until the next DONE or reset.
- `result_valid` and `div_by_zero` are never high outside DONE.

## Test plan
- Decode sweep: all `aluop` values, plus all 64 `func` values with `aluop` 0010 → `ops` matches the table, including 1111 for unlisted codes. `stall` stays 0 for single-cycle ops.
- Multiply (WIDTH=8): `a`=13, `b`=11, `func` 000010, accepted at cycle 0 → `stall` high in cycles 0..8; `result_valid` in cycle 9 with `result` = 0x8F. Then `a`=200, `b`=3 → `result` = 0x58.
- Divide / modulo (WIDTH=8): 200/7 → `result` = 28; 200%7 → `result` = 4. Each has `result_valid` in cycle 9 and `div_by_zero` = 0.
- Divide by zero: `a`=0x5A, `b`=0. `/` → `result` = 0xFF, `%` → `result` = 0x5A. `result_valid` and `div_by_zero` high in cycle 1; `stall` high only in cycle 0.
- Back-to-back: new `*` (5×6) presented during DONE of a prior `/` → first result taken, second accepted the same cycle; 30 delivered WIDTH+1 cycles later.
- Reset mid-RUN: `rst_n` low at cycle 4 of a multiply → all outputs 0 immediately, state IDLE, no `result_valid` after release; a fresh op then completes normally.
